// File: rtl/car_alarm_passive_ctrl.sv
// rtl/car_alarm_passive_ctrl.sv - passive car-alarm controller with auto-arm, entry delay and alarm timers
module car_alarm_passive_ctrl #(
  parameter int ARM_DELAY   = 4,
  parameter int ENTRY_DELAY = 3,
  parameter int ALARM_TIME  = 8,
  parameter int BEEP_HALF   = 2,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic reset_L,
  input  logic CarLightsOnSign,
  input  logic OpenDoorSign,
  input  logic IgnitionSignalOn,
  output logic PassiveSignal_b,
  output logic PassiveSignal_s
);

  localparam logic [2:0] DISARMED = 3'd0;
  localparam logic [2:0] ARM_WAIT = 3'd1;
  localparam logic [2:0] ARMED    = 3'd2;
  localparam logic [2:0] ENTRY    = 3'd3;
  localparam logic [2:0] ALARM    = 3'd4;

  localparam logic [CNT_W-1:0] ARM_LAST   = CNT_W'(ARM_DELAY - 1);
  localparam logic [CNT_W-1:0] ENTRY_LAST = CNT_W'(ENTRY_DELAY - 1);
  localparam logic [CNT_W-1:0] ALARM_LAST = CNT_W'(ALARM_TIME - 1);
  localparam logic [CNT_W-1:0] BEEP_LAST  = CNT_W'(BEEP_HALF - 1);

  logic [2:0]       state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [CNT_W-1:0] beepCnt, beepCntNext;
  logic             beepPhase, beepPhaseNext;
  logic             remind;
  logic             buzzNext, sirenNext;

  // Ignition overrides everything; door events take precedence over timer expiry.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    if (IgnitionSignalOn) begin
      stateNext = DISARMED;
      cntNext   = '0;
    end else begin
      case (state)
        DISARMED: begin
          if (!OpenDoorSign) begin
            stateNext = ARM_WAIT;
            cntNext   = '0;
          end
        end
        ARM_WAIT: begin
          if (OpenDoorSign) begin
            cntNext = '0;
          end else if (cnt == ARM_LAST) begin
            stateNext = ARMED;
            cntNext   = '0;
          end else begin
            cntNext = cnt + 1'b1;
          end
        end
        ARMED: begin
          if (OpenDoorSign) begin
            stateNext = ENTRY;
            cntNext   = '0;
          end
        end
        ENTRY: begin
          if (cnt == ENTRY_LAST) begin
            stateNext = ALARM;
            cntNext   = '0;
          end else begin
            cntNext = cnt + 1'b1;
          end
        end
        ALARM: begin
          if (cnt == ALARM_LAST) begin
            stateNext = OpenDoorSign ? ALARM : ARMED;
            cntNext   = '0;
          end else begin
            cntNext = cnt + 1'b1;
          end
        end
        default: begin
          stateNext = DISARMED;
          cntNext   = '0;
        end
      endcase
    end
  end

  always_comb begin
    remind = CarLightsOnSign & OpenDoorSign & ~IgnitionSignalOn &
             ((state == DISARMED) | (state == ARM_WAIT));
    beepCntNext   = '0;
    beepPhaseNext = 1'b0;
    if (remind) begin
      if (beepCnt == BEEP_LAST) begin
        beepCntNext   = '0;
        beepPhaseNext = ~beepPhase;
      end else begin
        beepCntNext   = beepCnt + 1'b1;
        beepPhaseNext = beepPhase;
      end
    end
    // Phase 0 maps to a high buzzer so the beep starts high.
    buzzNext  = (stateNext == ENTRY) | (remind & ~beepPhase);
    sirenNext = (stateNext == ALARM);
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state           <= DISARMED;
      cnt             <= '0;
      beepCnt         <= '0;
      beepPhase       <= 1'b0;
      PassiveSignal_b <= 1'b0;
      PassiveSignal_s <= 1'b0;
    end else begin
      state           <= stateNext;
      cnt             <= cntNext;
      beepCnt         <= beepCntNext;
      beepPhase       <= beepPhaseNext;
      PassiveSignal_b <= buzzNext;
      PassiveSignal_s <= sirenNext;
    end
  end

endmodule

// File: tb/tb_car_alarm_passive_ctrl.sv
// tb/tb_car_alarm_passive_ctrl.sv - directed self-checking bench for car_alarm_passive_ctrl
module tb_car_alarm_passive_ctrl;

  localparam logic [2:0] S_DISARMED = 3'd0;
  localparam logic [2:0] S_ARM_WAIT = 3'd1;
  localparam logic [2:0] S_ARMED    = 3'd2;
  localparam logic [2:0] S_ENTRY    = 3'd3;
  localparam logic [2:0] S_ALARM    = 3'd4;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  logic lights = 1'b0;
  logic door = 1'b0;
  logic ign = 1'b0;
  logic buzz, siren;

  int checks = 0;
  int errors = 0;

  car_alarm_passive_ctrl dut (
    .clk              (clk),
    .reset_L          (reset_L),
    .CarLightsOnSign  (lights),
    .OpenDoorSign     (door),
    .IgnitionSignalOn (ign),
    .PassiveSignal_b  (buzz),
    .PassiveSignal_s  (siren)
  );

  always #5 clk = ~clk;

  task automatic step(input logic l, input logic d, input logic i);
    lights = l;
    door   = d;
    ign    = i;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic eb, input logic es, input logic [2:0] est);
    chk({tag, ".b"}, {7'd0, buzz}, {7'd0, eb});
    chk({tag, ".s"}, {7'd0, siren}, {7'd0, es});
    chk({tag, ".state"}, {5'd0, dut.state}, {5'd0, est});
  endtask

  logic beepExp [6];

  initial begin
    beepExp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset held with random inputs
    reset_L = 1'b0;
    for (int k = 0; k < 2; k++) step(1'($urandom), 1'($urandom), 1'($urandom));
    chk_out("reset", 1'b0, 1'b0, S_DISARMED);
    reset_L = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    chk_out("release_ign", 1'b0, 1'b0, S_DISARMED);

    // Arming: ARM_WAIT at edge 1, ARMED at edge 5
    step(1'b0, 1'b0, 1'b0);
    chk_out("arm_e1", 1'b0, 1'b0, S_ARM_WAIT);
    for (int k = 2; k <= 4; k++) begin
      step(1'b0, 1'b0, 1'b0);
      chk_out("arm_wait", 1'b0, 1'b0, S_ARM_WAIT);
    end
    step(1'b0, 1'b0, 1'b0);
    chk_out("arm_e5", 1'b0, 1'b0, S_ARMED);

    // Entry at edge 6; closing the door does not cancel it
    step(1'b0, 1'b1, 1'b0);
    chk_out("entry_e6", 1'b1, 1'b0, S_ENTRY);
    for (int k = 7; k <= 8; k++) begin
      step(1'b0, 1'b0, 1'b0);
      chk_out("entry_e78", 1'b1, 1'b0, S_ENTRY);
    end
    for (int k = 9; k <= 16; k++) begin
      step(1'b0, 1'b0, 1'b0);
      chk_out("alarm_e9_16", 1'b0, 1'b1, S_ALARM);
    end
    step(1'b0, 1'b0, 1'b0);
    chk_out("alarm_end_e17", 1'b0, 1'b0, S_ARMED);

    // Alarm restart with door held open at expiry
    step(1'b0, 1'b1, 1'b0);
    chk_out("entry2", 1'b1, 1'b0, S_ENTRY);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk_out("alarm2_start", 1'b0, 1'b1, S_ALARM);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b1, 1'b0);
      chk_out("alarm2_restart", 1'b0, 1'b1, S_ALARM);
    end
    for (int k = 1; k <= 7; k++) begin
      step(1'b0, 1'b0, 1'b0);
      chk_out("alarm2_second", 1'b0, 1'b1, S_ALARM);
    end
    step(1'b0, 1'b0, 1'b0);
    chk_out("alarm2_end", 1'b0, 1'b0, S_ARMED);

    // Disarm at second edge of ENTRY
    step(1'b0, 1'b1, 1'b0);
    chk_out("dis_entry", 1'b1, 1'b0, S_ENTRY);
    step(1'b0, 1'b0, 1'b1);
    chk_out("dis_ign", 1'b0, 1'b0, S_DISARMED);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 1'b1);
      chk_out("dis_hold", 1'b0, 1'b0, S_DISARMED);
    end

    // Re-arm, reach ALARM, then ignition mid-alarm
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0);
    chk_out("rearm", 1'b0, 1'b0, S_ARMED);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0);
    chk_out("rearm_alarm", 1'b0, 1'b1, S_ALARM);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    chk_out("alarm_ign", 1'b0, 1'b0, S_DISARMED);

    // Reminder beep 1,1,0,0,1,1 then lights off
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b1, 1'b0);
      chk_out("remind", beepExp[k], 1'b0, S_DISARMED);
    end
    step(1'b0, 1'b1, 1'b0);
    chk_out("remind_off", 1'b0, 1'b0, S_DISARMED);

    // Arm restart: door opens at cnt=3
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0);
    chk_out("restart_cnt3", 1'b0, 1'b0, S_ARM_WAIT);
    step(1'b0, 1'b1, 1'b0);
    chk_out("restart_door", 1'b0, 1'b0, S_ARM_WAIT);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0);
      chk_out("restart_wait", 1'b0, 1'b0, S_ARM_WAIT);
    end
    step(1'b0, 1'b0, 1'b0);
    chk_out("restart_armed", 1'b0, 1'b0, S_ARMED);

    // Reset during ENTRY aborts at that edge
    step(1'b0, 1'b1, 1'b0);
    reset_L = 1'b0;
    step(1'b0, 1'b1, 1'b0);
    chk_out("reset_mid", 1'b0, 1'b0, S_DISARMED);
    reset_L = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
